// File: rtl/tdsp_bus_responder.sv
// Target-side responder: arbitrates TDSP prog/data/port requests onto one external bus with wait states.
// Optional abort-on-timeout logic is built only when TDSP_BUS_TIMEOUT_EN is defined.
module tdsp_bus_responder #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go_prog,
    input  logic        read_prog,
    input  logic        go_data,
    input  logic        read_data,
    input  logic        go_port,
    input  logic        read_port,
    input  logic [7:0]  addrs_in,
    input  logic [15:0] data_in,
    input  logic [11:0] p_addrs_in,
    input  logic [15:0] p_data_in,
    input  logic [2:0]  port_addrs_in,
    input  logic [15:0] port_data_in,
    output logic [15:0] data_out,
    output logic [15:0] p_data_out,
    output logic [15:0] port_data_out,
    output logic        done_prog,
    output logic        done_data,
    output logic        done_port,
    output logic        ovr,
    output logic        bus_err,
    output logic        ext_req,
    output logic        ext_we,
    output logic [1:0]  ext_space,
    output logic [11:0] ext_addr,
    output logic [15:0] ext_wdata,
    input  logic [15:0] ext_rdata,
    input  logic        ext_rdy
);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    localparam logic [1:0] SP_PROG = 2'b00;
    localparam logic [1:0] SP_DATA = 2'b01;
    localparam logic [1:0] SP_PORT = 2'b10;

    // Channel vectors are ordered {port, data, prog}.
    state_t      state_q, state_d;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  rd_q, rd_d;
    logic [11:0] p_addr_q, p_addr_d;
    logic [7:0]  d_addr_q, d_addr_d;
    logic [2:0]  pt_addr_q, pt_addr_d;
    logic [15:0] p_wd_q, p_wd_d;
    logic [15:0] d_wd_q, d_wd_d;
    logic [15:0] pt_wd_q, pt_wd_d;
    logic        ext_req_q, ext_req_d;
    logic        ext_we_q, ext_we_d;
    logic [1:0]  ext_space_q, ext_space_d;
    logic [11:0] ext_addr_q, ext_addr_d;
    logic [15:0] ext_wdata_q, ext_wdata_d;
    logic [3:0]  wait_q, wait_d;
    logic [2:0]  done_q, done_d;
    logic        ovr_q, ovr_d;
    logic [15:0] data_out_q, data_out_d;
    logic [15:0] p_data_out_q, p_data_out_d;
    logic [15:0] port_data_out_q, port_data_out_d;

    logic [2:0]  go_v, active_v, acc_v, eff_v;
    logic        finish;
    logic [15:0] rdata_v;

`ifdef TDSP_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d         = state_q;
        pending_d       = pending_q;
        rd_d            = rd_q;
        p_addr_d        = p_addr_q;
        d_addr_d        = d_addr_q;
        pt_addr_d       = pt_addr_q;
        p_wd_d          = p_wd_q;
        d_wd_d          = d_wd_q;
        pt_wd_d         = pt_wd_q;
        ext_req_d       = ext_req_q;
        ext_we_d        = ext_we_q;
        ext_space_d     = ext_space_q;
        ext_addr_d      = ext_addr_q;
        ext_wdata_d     = ext_wdata_q;
        wait_d          = wait_q;
        done_d          = 3'b000;
        ovr_d           = ovr_q;
        data_out_d      = data_out_q;
        p_data_out_d    = p_data_out_q;
        port_data_out_d = port_data_out_q;
        finish          = 1'b0;
        rdata_v         = ext_rdata;
`ifdef TDSP_BUS_TIMEOUT_EN
        tmo_d           = tmo_q;
        bus_err_d       = bus_err_q;
`endif

        go_v     = {go_port, go_data, go_prog};
        active_v = 3'b000;
        if (state_q == S_ACCESS) begin
            case (ext_space_q)
                SP_DATA: active_v = 3'b010;
                SP_PORT: active_v = 3'b100;
                default: active_v = 3'b001;
            endcase
        end
        acc_v = go_v & ~pending_q & ~active_v;
        eff_v = pending_q | acc_v;
        if ((go_v & ~acc_v) != 3'b000) ovr_d = 1'b1;

        // Accepted requests are captured first so the grant below sees the live go values.
        if (acc_v[0]) begin
            rd_d[0]  = read_prog;
            p_addr_d = p_addrs_in;
            p_wd_d   = p_data_in;
        end
        if (acc_v[1]) begin
            rd_d[1]  = read_data;
            d_addr_d = addrs_in;
            d_wd_d   = data_in;
        end
        if (acc_v[2]) begin
            rd_d[2]   = read_port;
            pt_addr_d = port_addrs_in;
            pt_wd_d   = port_data_in;
        end
        pending_d = pending_q | acc_v;

        case (state_q)
            S_IDLE: begin
`ifdef TDSP_BUS_TIMEOUT_EN
                tmo_d = '0;
`endif
                if (eff_v != 3'b000) begin
                    state_d   = S_ACCESS;
                    ext_req_d = 1'b1;
                    wait_d    = 4'(WAIT_STATES);
                    if (eff_v[1]) begin
                        ext_space_d = SP_DATA;
                        ext_we_d    = ~rd_d[1];
                        ext_addr_d  = {4'b0000, d_addr_d};
                        ext_wdata_d = d_wd_d;
                    end else if (eff_v[2]) begin
                        ext_space_d = SP_PORT;
                        ext_we_d    = ~rd_d[2];
                        ext_addr_d  = {9'b0, pt_addr_d};
                        ext_wdata_d = pt_wd_d;
                    end else begin
                        ext_space_d = SP_PROG;
                        ext_we_d    = ~rd_d[0];
                        ext_addr_d  = p_addr_d;
                        ext_wdata_d = p_wd_d;
                    end
                end
            end
            S_ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (ext_rdy) begin
                    finish = 1'b1;
                end
`ifdef TDSP_BUS_TIMEOUT_EN
                tmo_d = tmo_q + TW'(1);
                if (!finish && tmo_q == TW'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    rdata_v   = 16'hFFFF;
                    bus_err_d = 1'b1;
                end
`endif
                if (finish) begin
                    done_d    = active_v;
                    pending_d = pending_d & ~active_v;
                    ext_req_d = 1'b0;
                    state_d   = S_IDLE;
                    if (!ext_we_q) begin
                        case (ext_space_q)
                            SP_DATA: data_out_d      = rdata_v;
                            SP_PORT: port_data_out_d = rdata_v;
                            default: p_data_out_d    = rdata_v;
                        endcase
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pending_q       <= '0;
            rd_q            <= '0;
            p_addr_q        <= '0;
            d_addr_q        <= '0;
            pt_addr_q       <= '0;
            p_wd_q          <= '0;
            d_wd_q          <= '0;
            pt_wd_q         <= '0;
            ext_req_q       <= 1'b0;
            ext_we_q        <= 1'b0;
            ext_space_q     <= '0;
            ext_addr_q      <= '0;
            ext_wdata_q     <= '0;
            wait_q          <= '0;
            done_q          <= '0;
            ovr_q           <= 1'b0;
            data_out_q      <= '0;
            p_data_out_q    <= '0;
            port_data_out_q <= '0;
`ifdef TDSP_BUS_TIMEOUT_EN
            tmo_q           <= '0;
            bus_err_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            rd_q            <= rd_d;
            p_addr_q        <= p_addr_d;
            d_addr_q        <= d_addr_d;
            pt_addr_q       <= pt_addr_d;
            p_wd_q          <= p_wd_d;
            d_wd_q          <= d_wd_d;
            pt_wd_q         <= pt_wd_d;
            ext_req_q       <= ext_req_d;
            ext_we_q        <= ext_we_d;
            ext_space_q     <= ext_space_d;
            ext_addr_q      <= ext_addr_d;
            ext_wdata_q     <= ext_wdata_d;
            wait_q          <= wait_d;
            done_q          <= done_d;
            ovr_q           <= ovr_d;
            data_out_q      <= data_out_d;
            p_data_out_q    <= p_data_out_d;
            port_data_out_q <= port_data_out_d;
`ifdef TDSP_BUS_TIMEOUT_EN
            tmo_q           <= tmo_d;
            bus_err_q       <= bus_err_d;
`endif
        end
    end

    assign data_out      = data_out_q;
    assign p_data_out    = p_data_out_q;
    assign port_data_out = port_data_out_q;
    assign done_prog     = done_q[0];
    assign done_data     = done_q[1];
    assign done_port     = done_q[2];
    assign ovr           = ovr_q;
    assign ext_req       = ext_req_q;
    assign ext_we        = ext_we_q;
    assign ext_space     = ext_space_q;
    assign ext_addr      = ext_addr_q;
    assign ext_wdata     = ext_wdata_q;
`ifdef TDSP_BUS_TIMEOUT_EN
    assign bus_err       = bus_err_q;
`else
    assign bus_err       = 1'b0;
`endif

endmodule

// File: tb/tb_tdsp_bus_responder.sv
// Directed bench for tdsp_bus_responder (WAIT_STATES=1): reset, reads, slow writes, arbitration, overrun.
module tb_tdsp_bus_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go_prog = 0, read_prog = 0, go_data = 0, read_data = 0, go_port = 0, read_port = 0;
    logic [7:0]  addrs_in = '0;
    logic [15:0] data_in = '0;
    logic [11:0] p_addrs_in = '0;
    logic [15:0] p_data_in = '0;
    logic [2:0]  port_addrs_in = '0;
    logic [15:0] port_data_in = '0;
    logic [15:0] data_out, p_data_out, port_data_out;
    logic        done_prog, done_data, done_port, ovr, bus_err;
    logic        ext_req, ext_we;
    logic [1:0]  ext_space;
    logic [11:0] ext_addr;
    logic [15:0] ext_wdata;
    logic [15:0] ext_rdata = '0;
    logic        ext_rdy = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    tdsp_bus_responder #(.WAIT_STATES(1), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .go_prog(go_prog), .read_prog(read_prog),
        .go_data(go_data), .read_data(read_data),
        .go_port(go_port), .read_port(read_port),
        .addrs_in(addrs_in), .data_in(data_in),
        .p_addrs_in(p_addrs_in), .p_data_in(p_data_in),
        .port_addrs_in(port_addrs_in), .port_data_in(port_data_in),
        .data_out(data_out), .p_data_out(p_data_out), .port_data_out(port_data_out),
        .done_prog(done_prog), .done_data(done_data), .done_port(done_port),
        .ovr(ovr), .bus_err(bus_err),
        .ext_req(ext_req), .ext_we(ext_we), .ext_space(ext_space),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_rdy(ext_rdy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(); cyc();
        n_cmp++;
        if ({ext_req, ext_we, ext_space, ext_addr, ext_wdata} !== 32'h0) begin
            n_bad++; $display("FAIL reset_ext: got %h want 0", {ext_req, ext_we, ext_space, ext_addr, ext_wdata});
        end
        n_cmp++;
        if ({data_out, p_data_out, port_data_out} !== 48'h0) begin
            n_bad++; $display("FAIL reset_hold: got %h want 0", {data_out, p_data_out, port_data_out});
        end
        n_cmp++;
        if ({done_prog, done_data, done_port, ovr, bus_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 00000", {done_prog, done_data, done_port, ovr, bus_err});
        end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_data_read();
        ext_rdy = 1'b1; ext_rdata = 16'h1234;
        go_data = 1'b1; read_data = 1'b1; addrs_in = 8'h85;
        cyc();
        go_data = 1'b0; addrs_in = 8'h00;
        n_cmp++;
        if ({ext_req, ext_we, ext_space, ext_addr} !== {1'b1, 1'b0, 2'b01, 12'h085}) begin
            n_bad++; $display("FAIL rd_issue: got req=%b we=%b sp=%b addr=%h want 1 0 01 085", ext_req, ext_we, ext_space, ext_addr);
        end
        cyc();
        n_cmp++;
        if ({ext_req, done_data} !== 2'b10) begin
            n_bad++; $display("FAIL rd_wait: got req/done %b want 10", {ext_req, done_data});
        end
        cyc();
        n_cmp++;
        if ({ext_req, done_data, data_out} !== {2'b01, 16'h1234}) begin
            n_bad++; $display("FAIL rd_done: got req=%b done=%b data=%h want 0 1 1234", ext_req, done_data, data_out);
        end
        cyc();
        n_cmp++;
        if ({done_data, data_out} !== {1'b0, 16'h1234}) begin
            n_bad++; $display("FAIL rd_pulse: got done=%b data=%h want 0 1234", done_data, data_out);
        end
    endtask

    task automatic test_port_write();
        ext_rdy = 1'b0;
        go_port = 1'b1; read_port = 1'b0; port_addrs_in = 3'd5; port_data_in = 16'hBEEF;
        cyc();
        go_port = 1'b0; port_addrs_in = 3'd0; port_data_in = 16'h0000;
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if ({ext_req, ext_we, ext_space, ext_addr, ext_wdata, done_port} !== {2'b11, 2'b10, 12'h005, 16'hBEEF, 1'b0}) begin
                n_bad++; $display("FAIL wr_hold%0d: got req=%b we=%b sp=%b addr=%h wd=%h done=%b want 1 1 10 005 beef 0",
                                  k, ext_req, ext_we, ext_space, ext_addr, ext_wdata, done_port);
            end
            cyc();
        end
        n_cmp++;
        if ({ext_req, ext_wdata, done_port} !== {1'b1, 16'hBEEF, 1'b0}) begin
            n_bad++; $display("FAIL wr_before_rdy: got req=%b wd=%h done=%b want 1 beef 0", ext_req, ext_wdata, done_port);
        end
        ext_rdy = 1'b1;
        cyc();
        n_cmp++;
        if ({ext_req, done_port, port_data_out} !== {2'b01, 16'h0000}) begin
            n_bad++; $display("FAIL wr_done: got req=%b done=%b pout=%h want 0 1 0000", ext_req, done_port, port_data_out);
        end
        cyc();
    endtask

    task automatic test_arbitration();
        logic        exp_req  [1:10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
        logic [1:0]  exp_sp   [1:10] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [2:0]  exp_done [1:10] = '{3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b001, 3'b000};
        ext_rdy = 1'b1; ext_rdata = 16'hA000;
        go_prog = 1; read_prog = 1; p_addrs_in = 12'hABC;
        go_data = 1; read_data = 1; addrs_in = 8'h10;
        go_port = 1; read_port = 1; port_addrs_in = 3'd3;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            go_prog = 0; go_data = 0; go_port = 0;
            n_cmp++;
            if (ext_req !== exp_req[k] || (exp_req[k] && ext_space !== exp_sp[k]) ||
                {done_port, done_data, done_prog} !== exp_done[k]) begin
                n_bad++; $display("FAIL arb_c%0d: got req=%b sp=%b done=%b want req=%b sp=%b done=%b", k,
                                  ext_req, ext_space, {done_port, done_data, done_prog}, exp_req[k], exp_sp[k], exp_done[k]);
            end
            if (k == 7) begin
                n_cmp++;
                if (ext_addr !== 12'hABC) begin
                    n_bad++; $display("FAIL arb_paddr: got %h want abc", ext_addr);
                end
            end
            ext_rdata = 16'hA000 + 16'(k);
        end
        n_cmp++;
        if ({data_out, port_data_out, p_data_out} !== {16'hA002, 16'hA005, 16'hA008}) begin
            n_bad++; $display("FAIL arb_hold: got %h %h %h want a002 a005 a008", data_out, port_data_out, p_data_out);
        end
    endtask

    task automatic test_overrun();
        int dones = 0;
        n_cmp++;
        if (ovr !== 1'b0) begin
            n_bad++; $display("FAIL ovr_pre: got %b want 0", ovr);
        end
        ext_rdy = 1'b1;
        go_data = 1; read_data = 1; addrs_in = 8'h22;
        cyc();
        for (int k = 1; k <= 8; k++) begin
            go_data = (k == 1);
            if (done_data) dones++;
            if (k == 3) begin
                n_cmp++;
                if (ovr !== 1'b1) begin
                    n_bad++; $display("FAIL ovr_set: got %b want 1", ovr);
                end
            end
            cyc();
        end
        n_cmp++;
        if (dones != 1) begin
            n_bad++; $display("FAIL ovr_dones: got %0d want 1", dones);
        end
        n_cmp++;
        if (ovr !== 1'b1) begin
            n_bad++; $display("FAIL ovr_sticky: got %b want 1", ovr);
        end
    endtask

    task automatic test_reset_mid_access();
        int dones = 0;
        ext_rdy = 1'b0;
        go_data = 1; read_data = 1; addrs_in = 8'h33;
        cyc();
        go_data = 0;
        cyc();
        n_cmp++;
        if (ext_req !== 1'b1) begin
            n_bad++; $display("FAIL mid_active: got %b want 1", ext_req);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({ext_req, done_data, ovr} !== 3'b000) begin
            n_bad++; $display("FAIL mid_async: got req/done/ovr %b want 000", {ext_req, done_data, ovr});
        end
        n_cmp++;
        if ({data_out, p_data_out, port_data_out} !== 48'h0) begin
            n_bad++; $display("FAIL mid_hold: got %h want 0", {data_out, p_data_out, port_data_out});
        end
        cyc();
        reset = 1'b0; ext_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (done_data || ext_req) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++; $display("FAIL mid_no_done: got %0d busy/done cycles want 0", dones);
        end
    endtask

`ifdef TDSP_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int done_at = 0;
        ext_rdy = 1'b0;
        go_prog = 1; read_prog = 1; p_addrs_in = 12'h123;
        cyc();
        go_prog = 0;
        for (int k = 1; k <= 70; k++) begin
            if (done_prog && done_at == 0) done_at = k;
            cyc();
        end
        n_cmp++;
        if (done_at != 65 || p_data_out !== 16'hFFFF || bus_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout: got done@%0d pout=%h err=%b want 65 ffff 1", done_at, p_data_out, bus_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_data_read();
        test_port_write();
        test_arbitration();
        test_overrun();
        test_reset_mid_access();
`ifdef TDSP_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
